// File: rtl/credit_pool_pkg.sv
// Shared types and helpers for the credit pool arbiter.
package credit_pool_pkg;

    typedef enum logic {ARB = 1'b0, RESERVE = 1'b1} arb_state_e;

    localparam int unsigned MinNumReq       = 2;
    localparam int unsigned MinStarveCycles = 1;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/credit_pool_arbiter_if.sv
// Request, return and status signals of the credit pool arbiter.
interface credit_pool_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8
);
    logic                       clear_i;
    logic                       load_i;
    logic [WIDTH-1:0]           load_val_i;
    logic [NUM_REQ-1:0]         req_valid_i;
    logic [NUM_REQ*WIDTH-1:0]   req_amt_i;
    logic [NUM_REQ-1:0]         req_ready_o;
    logic                       ret_valid_i;
    logic [WIDTH-1:0]           ret_amt_i;
    logic [WIDTH-1:0]           credits_o;
    logic                       reserved_o;
    logic                       ovf_o;

    modport master (
        output clear_i, load_i, load_val_i, req_valid_i, req_amt_i, ret_valid_i, ret_amt_i,
        input  req_ready_o, credits_o, reserved_o, ovf_o
    );

    modport slave (
        input  clear_i, load_i, load_val_i, req_valid_i, req_amt_i, ret_valid_i, ret_amt_i,
        output req_ready_o, credits_o, reserved_o, ovf_o
    );
endinterface

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set bit of elig_i scanning from ptr_i upward, wrapping.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IdxW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] elig_i,
    input  logic [IdxW-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IdxW-1:0]    idx_o,
    output logic               any_o
);
    logic [IdxW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IdxW'((32'(ptr_i) + k) % NUM_REQ);
            if (!any_o && elig_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end
endmodule

// File: rtl/credit_pool_arbiter.sv
// Round-robin arbiter sharing one saturating credit pool, with a starvation reservation.
module credit_pool_arbiter
    import credit_pool_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned MAX_CREDITS   = 200,
    parameter int unsigned INIT_CREDITS  = 16,
    parameter int unsigned STARVE_CYCLES = 8
) (
    input logic clk_i,
    input logic rst_i,
    credit_pool_arbiter_if.slave bus
);
    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(STARVE_CYCLES + 1);
    localparam logic [WIDTH-1:0] MaxCred  = WIDTH'(MAX_CREDITS);
    localparam logic [WIDTH-1:0] InitCred = WIDTH'(INIT_CREDITS);

    if (NUM_REQ < MinNumReq) begin : g_chk_num_req
        $error("NUM_REQ must be at least 2");
    end
    if (STARVE_CYCLES < MinStarveCycles) begin : g_chk_starve
        $error("STARVE_CYCLES must be at least 1");
    end
    if ((MAX_CREDITS >> WIDTH) != 0) begin : g_chk_max
        $error("MAX_CREDITS must fit in WIDTH bits");
    end
    if (INIT_CREDITS > MAX_CREDITS) begin : g_chk_init
        $error("INIT_CREDITS must not exceed MAX_CREDITS");
    end

    arb_state_e         state_q, state_d;
    logic [IdxW-1:0]    ptr_q, ptr_d;
    logic [CntW-1:0]    starve_q, starve_d;
    logic [WIDTH-1:0]   pool_q, pool_d;
    logic               ovf_q, ovf_d;

    logic [NUM_REQ-1:0] elig, rr_gnt, ready;
    logic [IdxW-1:0]    rr_idx;
    logic               rr_any;
    logic [WIDTH-1:0]   head_amt, rr_amt, gnt_amt;
    logic               head_valid, head_blocked;
    logic [WIDTH:0]     ret_ext, sum;

    // Eligibility looks only at the registered pool; same-cycle returns do not count.
    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            elig[i] = bus.req_valid_i[i] && (bus.req_amt_i[i*WIDTH +: WIDTH] <= pool_q);
        end
    end

    assign head_amt     = bus.req_amt_i[32'(ptr_q)*WIDTH +: WIDTH];
    assign rr_amt       = bus.req_amt_i[32'(rr_idx)*WIDTH +: WIDTH];
    assign head_valid   = bus.req_valid_i[ptr_q];
    assign head_blocked = head_valid && !elig[ptr_q];

    rr_pick #(
        .NUM_REQ(NUM_REQ),
        .IdxW   (IdxW)
    ) u_rr_pick (
        .elig_i(elig),
        .ptr_i (ptr_q),
        .gnt_o (rr_gnt),
        .idx_o (rr_idx),
        .any_o (rr_any)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        starve_d = starve_q;
        pool_d   = pool_q;
        ovf_d    = ovf_q;
        ready    = '0;
        gnt_amt  = '0;
        ret_ext  = '0;
        sum      = '0;
        if (bus.clear_i) begin
            pool_d   = '0;
            ovf_d    = 1'b0;
            state_d  = ARB;
            starve_d = '0;
        end else if (bus.load_i) begin
            pool_d   = (bus.load_val_i > MaxCred) ? MaxCred : bus.load_val_i;
            state_d  = ARB;
            starve_d = '0;
        end else begin
            unique case (state_q)
                ARB: begin
                    ready = rr_gnt;
                    if (rr_any) begin
                        gnt_amt = rr_amt;
                    end
                    // A blocked head keeps the pointer so its wait is not forgotten.
                    if (head_blocked) begin
                        starve_d = starve_q + 1'b1;
                        if (32'(starve_q) + 32'd1 >= STARVE_CYCLES) begin
                            state_d = RESERVE;
                        end
                    end else begin
                        starve_d = '0;
                        if (rr_any) begin
                            ptr_d = IdxW'(rr_next(32'(rr_idx), NUM_REQ));
                        end
                    end
                end
                RESERVE: begin
                    if (!head_valid) begin
                        state_d  = ARB;
                        starve_d = '0;
                    end else if (elig[ptr_q]) begin
                        ready[ptr_q] = 1'b1;
                        gnt_amt      = head_amt;
                        ptr_d        = IdxW'(rr_next(32'(ptr_q), NUM_REQ));
                        state_d      = ARB;
                        starve_d     = '0;
                    end
                end
                default: state_d = ARB;
            endcase
            ret_ext = bus.ret_valid_i ? {1'b0, bus.ret_amt_i} : '0;
            sum     = {1'b0, pool_q} + ret_ext - {1'b0, gnt_amt};
            if (sum > {1'b0, MaxCred}) begin
                pool_d = MaxCred;
                ovf_d  = 1'b1;
            end else begin
                pool_d = sum[WIDTH-1:0];
            end
        end
        if (rst_i) begin
            ready = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ARB;
            ptr_q    <= '0;
            starve_q <= '0;
            pool_q   <= InitCred;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            starve_q <= starve_d;
            pool_q   <= pool_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.req_ready_o = ready;
    assign bus.credits_o   = pool_q;
    assign bus.reserved_o  = (state_q == RESERVE);
    assign bus.ovf_o       = ovf_q;

    ap_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(bus.req_ready_o));
    ap_rdy_vld: assert property (@(posedge clk_i) disable iff (rst_i)
        (bus.req_ready_o & ~bus.req_valid_i) == '0);
    ap_cred_max: assert property (@(posedge clk_i) disable iff (rst_i) pool_q <= MaxCred);
    // An oversized head in RESERVE can never be served and holds the pool.
    ap_reserve_deadlock: assert property (@(posedge clk_i) disable iff (rst_i)
        !(state_q == RESERVE && head_valid && head_amt > MaxCred));
endmodule

// File: tb/tb_credit_pool_arbiter.sv
// Directed bench: driver queues expected outputs per cycle, monitor checks them at negedge.
module tb_credit_pool_arbiter;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    credit_pool_arbiter_if #(.NUM_REQ(4), .WIDTH(8)) bus ();

    credit_pool_arbiter #(
        .NUM_REQ      (4),
        .WIDTH        (8),
        .MAX_CREDITS  (200),
        .INIT_CREDITS (16),
        .STARVE_CYCLES(8)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    typedef struct {
        string      name;
        logic [3:0] rdy;
        logic [7:0] cred;
        logic       res;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string nm, input string fld, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s %s: actual %0d required %0d", nm, fld, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check(mon_e.name, "ready", 32'(bus.req_ready_o), 32'(mon_e.rdy));
            check(mon_e.name, "credits", 32'(bus.credits_o), 32'(mon_e.cred));
            check(mon_e.name, "reserved", 32'(bus.reserved_o), 32'(mon_e.res));
            check(mon_e.name, "ovf", 32'(bus.ovf_o), 32'(mon_e.ovf));
        end
    end

    task automatic step(input string nm, input logic [3:0] rdy, input logic [7:0] cred,
                        input logic res, input logic ovf);
        exp_t e;
        e.name = nm;
        e.rdy  = rdy;
        e.cred = cred;
        e.res  = res;
        e.ovf  = ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] a);
        bus.req_valid_i[i]       = v;
        bus.req_amt_i[i*8 +: 8] = a;
    endtask

    task automatic idle();
        bus.clear_i     = 1'b0;
        bus.load_i      = 1'b0;
        bus.load_val_i  = '0;
        bus.req_valid_i = '0;
        bus.req_amt_i   = '0;
        bus.ret_valid_i = 1'b0;
        bus.ret_amt_i   = '0;
    endtask

    task automatic ret(input logic v, input logic [7:0] a);
        bus.ret_valid_i = v;
        bus.ret_amt_i   = a;
    endtask

    task automatic load(input logic [7:0] v);
        bus.load_i     = 1'b1;
        bus.load_val_i = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'd4);
        @(posedge clk);
        #1;
        // Eligible requests present, but reset masks every grant.
        step("reset", 4'b0000, 8'd16, 1'b0, 1'b0);
        rst = 1'b0;

        step("rr0", 4'b0001, 8'd16, 1'b0, 1'b0);
        step("rr1", 4'b0010, 8'd12, 1'b0, 1'b0);
        step("rr2", 4'b0100, 8'd8, 1'b0, 1'b0);
        step("rr3", 4'b1000, 8'd4, 1'b0, 1'b0);
        idle();
        step("rr_end", 4'b0000, 8'd0, 1'b0, 1'b0);

        // Load overrides grants and discards the return.
        load(8'd5);
        ret(1'b1, 8'd7);
        set_req(0, 1'b1, 8'd0);
        step("load5", 4'b0000, 8'd0, 1'b0, 1'b0);
        idle();
        set_req(0, 1'b1, 8'd0);
        set_req(2, 1'b1, 8'd0);
        step("zero_a", 4'b0001, 8'd5, 1'b0, 1'b0);
        step("zero_b", 4'b0100, 8'd5, 1'b0, 1'b0);

        idle();
        set_req(0, 1'b1, 8'd8);
        set_req(1, 1'b1, 8'd2);
        step("elig_a", 4'b0010, 8'd5, 1'b0, 1'b0);
        step("elig_b", 4'b0010, 8'd3, 1'b0, 1'b0);
        step("elig_c", 4'b0000, 8'd1, 1'b0, 1'b0);

        idle();
        set_req(3, 1'b1, 8'd0);
        step("ptr_to0", 4'b1000, 8'd1, 1'b0, 1'b0);
        idle();
        load(8'd10);
        step("load10", 4'b0000, 8'd1, 1'b0, 1'b0);

        idle();
        set_req(0, 1'b1, 8'd20);
        set_req(1, 1'b1, 8'd1);
        for (int k = 0; k < 8; k++) step("starve", 4'b0010, 8'(10 - k), 1'b0, 1'b0);
        ret(1'b1, 8'd18);
        step("reserve", 4'b0000, 8'd2, 1'b1, 1'b0);
        ret(1'b0, 8'd0);
        step("reserve_gnt", 4'b0001, 8'd20, 1'b1, 1'b0);
        idle();
        step("reserve_exit", 4'b0000, 8'd0, 1'b0, 1'b0);

        load(8'd195);
        step("load195", 4'b0000, 8'd0, 1'b0, 1'b0);
        idle();
        ret(1'b1, 8'd5);
        step("sat_exact", 4'b0000, 8'd195, 1'b0, 1'b0);
        idle();
        load(8'd198);
        step("load198", 4'b0000, 8'd200, 1'b0, 1'b0);
        idle();
        ret(1'b1, 8'd5);
        step("sat_clip", 4'b0000, 8'd198, 1'b0, 1'b0);
        idle();
        bus.clear_i = 1'b1;
        step("ovf_set", 4'b0000, 8'd200, 1'b0, 1'b1);
        idle();
        load(8'd7);
        step("cleared", 4'b0000, 8'd0, 1'b0, 1'b0);

        idle();
        set_req(2, 1'b1, 8'd7);
        ret(1'b1, 8'd3);
        step("same_cycle", 4'b0100, 8'd7, 1'b0, 1'b0);
        idle();
        load(8'd2);
        step("load2", 4'b0000, 8'd3, 1'b0, 1'b0);
        idle();
        set_req(3, 1'b1, 8'd4);
        ret(1'b1, 8'd5);
        step("no_early", 4'b0000, 8'd2, 1'b0, 1'b0);
        ret(1'b0, 8'd0);
        step("late_gnt", 4'b1000, 8'd7, 1'b0, 1'b0);

        idle();
        set_req(1, 1'b1, 8'd0);
        step("ptr_to2", 4'b0010, 8'd3, 1'b0, 1'b0);
        idle();
        bus.clear_i = 1'b1;
        step("clear2", 4'b0000, 8'd3, 1'b0, 1'b0);
        idle();
        set_req(2, 1'b1, 8'd5);
        set_req(3, 1'b1, 8'd0);
        for (int k = 0; k < 8; k++) step("starve2", 4'b1000, 8'd0, 1'b0, 1'b0);
        step("reserve2", 4'b0000, 8'd0, 1'b1, 1'b0);
        rst = 1'b1;
        set_req(0, 1'b1, 8'd0);
        step("rst_in_res", 4'b0000, 8'd0, 1'b1, 1'b0);
        rst = 1'b0;
        step("post_rst", 4'b0001, 8'd16, 1'b0, 1'b0);

        idle();
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL drain: actual %0d pending required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
